// File: rtl/branch_pc_unit.sv
// Program counter with conditional branch resolution and taken/not-taken statistics.
module branch_pc_unit #(
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned IMM_WIDTH = 19,
   parameter int unsigned CNT_WIDTH = 16,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 PCin,
   input  logic                 IncPC,
   input  logic                 BrStart,
   input  logic                 ConFFOut,
   input  logic [31:0]          IRout,
   input  logic [PC_WIDTH-1:0]  BusMuxOut,
   output logic [PC_WIDTH-1:0]  PC,
   output logic                 BrBusy,
   output logic                 BrTaken,
   output logic                 BrDone,
   output logic [CNT_WIDTH-1:0] TakenCnt,
   output logic [CNT_WIDTH-1:0] NotTakenCnt
);

   localparam int unsigned IR_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [PC_WIDTH-1:0]  base_q, base_d;
   logic [PC_WIDTH-1:0]  imm_q, imm_d;
   logic [PC_WIDTH-1:0]  target_q, target_d;
   logic                 con_q, con_d;
   logic                 busy_q, busy_d;
   logic                 taken_q, taken_d;
   logic                 done_q, done_d;
   logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;
   logic [CNT_WIDTH-1:0] ntcnt_q, ntcnt_d;

   // Only the immediate field of the instruction is used here.
   logic unused_ir;
   assign unused_ir = ^IRout[IR_WIDTH-1:IMM_WIDTH];

   // State and datapath registers; reset abandons any in-flight branch.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= IDLE;
         pc_q     <= PC_WIDTH'(RESET_PC);
         base_q   <= '0;
         imm_q    <= '0;
         target_q <= '0;
         con_q    <= 1'b0;
         busy_q   <= 1'b0;
         taken_q  <= 1'b0;
         done_q   <= 1'b0;
         tcnt_q   <= '0;
         ntcnt_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         base_q   <= base_d;
         imm_q    <= imm_d;
         target_q <= target_d;
         con_q    <= con_d;
         busy_q   <= busy_d;
         taken_q  <= taken_d;
         done_q   <= done_d;
         tcnt_q   <= tcnt_d;
         ntcnt_q  <= ntcnt_d;
      end
   end

   // Next-state, PC update and commit pulses.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      base_d   = base_q;
      imm_d    = imm_q;
      target_d = target_q;
      con_d    = con_q;
      busy_d   = busy_q;
      taken_d  = 1'b0;
      done_d   = 1'b0;
      tcnt_d   = tcnt_q;
      ntcnt_d  = ntcnt_q;
      case (state_q)
         IDLE: begin
            if (PCin) begin
               pc_d = BusMuxOut;
            end else if (IncPC) begin
               pc_d = pc_q + PC_WIDTH'(1);
            end
            // Base is the PC before any same-cycle load or increment.
            if (BrStart) begin
               base_d  = pc_q;
               imm_d   = PC_WIDTH'($signed(IRout[IMM_WIDTH-1:0]));
               con_d   = ConFFOut;
               busy_d  = 1'b1;
               state_d = EVAL;
            end
         end
         EVAL: begin
            target_d = base_q + imm_q;
            state_d  = COMMIT;
         end
         COMMIT: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
            if (con_q) begin
               pc_d    = target_q;
               taken_d = 1'b1;
               if (tcnt_q != '1) begin
                  tcnt_d = tcnt_q + CNT_WIDTH'(1);
               end
            end else if (ntcnt_q != '1) begin
               ntcnt_d = ntcnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign PC          = pc_q;
   assign BrBusy      = busy_q;
   assign BrTaken     = taken_q;
   assign BrDone      = done_q;
   assign TakenCnt    = tcnt_q;
   assign NotTakenCnt = ntcnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: driver with reference model, monitor on BrDone.
module tb_branch_pc_unit;

   logic        clk = 1'b0;
   logic        clr;
   logic        PCin, IncPC, BrStart, ConFFOut;
   logic [31:0] IRout, BusMuxOut;

   logic [31:0] PC, PC2;
   logic        BrBusy, BrTaken, BrDone, BrBusy2, BrTaken2, BrDone2;
   logic [15:0] TakenCnt, NotTakenCnt;
   logic [1:0]  TakenCnt2, NotTakenCnt2;

   always #5 clk = ~clk;

   branch_pc_unit u_dut (
      .clk(clk), .clr(clr), .PCin(PCin), .IncPC(IncPC), .BrStart(BrStart),
      .ConFFOut(ConFFOut), .IRout(IRout), .BusMuxOut(BusMuxOut),
      .PC(PC), .BrBusy(BrBusy), .BrTaken(BrTaken), .BrDone(BrDone),
      .TakenCnt(TakenCnt), .NotTakenCnt(NotTakenCnt)
   );

   branch_pc_unit #(.CNT_WIDTH(2)) u_dut_c2 (
      .clk(clk), .clr(clr), .PCin(PCin), .IncPC(IncPC), .BrStart(BrStart),
      .ConFFOut(ConFFOut), .IRout(IRout), .BusMuxOut(BusMuxOut),
      .PC(PC2), .BrBusy(BrBusy2), .BrTaken(BrTaken2), .BrDone(BrDone2),
      .TakenCnt(TakenCnt2), .NotTakenCnt(NotTakenCnt2)
   );

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      int          tc;
      int          ntc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_commit;
   int          m_busy;
   int          m_tc, m_ntc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   // One clock of stimulus; model advances as the DUT should across this edge.
   task automatic step(input logic pcin, input logic inc, input logic brs, input logic con,
                       input logic [31:0] ir, input logic [31:0] bus);
      logic [31:0] base;
      logic [31:0] target;
      int          imm;
      PCin = pcin; IncPC = inc; BrStart = brs; ConFFOut = con; IRout = ir; BusMuxOut = bus;
      @(posedge clk);
      #1;
      if (m_busy == 0) begin
         base = m_pc;
         if (pcin)     m_pc = bus;
         else if (inc) m_pc = m_pc + 32'd1;
         if (brs) begin
            imm = int'(ir[18:0]);
            if (imm >= 262144) imm = imm - 524288;
            target = base + 32'(imm);
            if (con) m_tc++;
            else     m_ntc++;
            m_commit = con ? target : m_pc;
            q.push_back('{m_commit, con, m_tc, m_ntc});
            m_busy = 2;
         end
      end else begin
         m_busy--;
         if (m_busy == 0) m_pc = m_commit;
      end
      check("pc", PC, m_pc);
      check("pc_c2", PC2, m_pc);
      check("busy", 32'(BrBusy), 32'(m_busy != 0));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'h0, 32'h0);
   endtask

   task automatic branch(input logic [31:0] ir, input logic con);
      step(0, 0, 1, con, ir, 32'h0);
      idle(2);
   endtask

   // Monitor: every commit pulse is matched against the oldest expected branch.
   always @(negedge clk) begin
      exp_t e;
      if (!clr) begin
         if (BrDone || BrDone2) begin
            check("done_pair", 32'(BrDone), 32'(BrDone2));
            check("scoreboard_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               check("commit_pc", PC, e.pc);
               check("br_taken", 32'(BrTaken), 32'(e.taken));
               check("taken_cnt", 32'(TakenCnt), 32'(e.tc));
               check("not_taken_cnt", 32'(NotTakenCnt), 32'(e.ntc));
               check("taken_cnt_sat", 32'(TakenCnt2), 32'(sat3(e.tc)));
               check("not_taken_cnt_sat", 32'(NotTakenCnt2), 32'(sat3(e.ntc)));
            end
         end else if (BrTaken || BrTaken2) begin
            check("taken_without_done", 32'(BrTaken | BrTaken2), 32'd0);
         end
      end
   end

   task automatic check_reset_state();
      check("rst_pc", PC, 32'h0);
      check("rst_busy", 32'(BrBusy), 32'd0);
      check("rst_done", 32'(BrDone), 32'd0);
      check("rst_taken", 32'(BrTaken), 32'd0);
      check("rst_tcnt", 32'(TakenCnt), 32'd0);
      check("rst_ntcnt", 32'(NotTakenCnt), 32'd0);
      check("rst_tcnt_c2", 32'(TakenCnt2), 32'd0);
   endtask

   initial begin
      clr = 1'b1;
      PCin = 0; IncPC = 0; BrStart = 0; ConFFOut = 0; IRout = '0; BusMuxOut = '0;
      m_pc = 32'h0; m_commit = 32'h0; m_busy = 0; m_tc = 0; m_ntc = 0;
      #1;
      check_reset_state();
      #11;
      clr = 1'b0;

      // Load priority and taken branch with positive offset
      step(1, 1, 0, 0, 32'h0, 32'h0000_1234);
      step(1, 0, 0, 0, 32'h0, 32'h0000_0010);
      branch(32'h0000_0005, 1'b1);
      // Negative offset taken, then not taken
      step(1, 0, 0, 0, 32'h0, 32'h0000_0010);
      branch(32'hFFF7_FFFC, 1'b1);
      step(1, 0, 0, 0, 32'h0, 32'h0000_0010);
      branch(32'h0007_FFFC, 1'b0);
      // Condition changes and PC controls during resolution are ignored
      step(1, 0, 0, 0, 32'h0, 32'h0000_0100);
      step(0, 0, 1, 1, 32'h0000_0020, 32'h0);
      step(1, 1, 1, 0, 32'h0000_0003, 32'hDEAD_BEEF);
      step(1, 1, 1, 0, 32'h0000_0007, 32'hCAFE_F00D);
      idle(1);
      // Branch issued together with a load: base is the pre-load PC
      step(1, 0, 1, 1, 32'h0000_0008, 32'h0000_5000);
      idle(3);
      // Increment wrap
      step(1, 0, 0, 0, 32'h0, 32'hFFFF_FFFF);
      step(0, 1, 0, 0, 32'h0, 32'h0);

      // Reset in the middle of EVAL drops the branch silently
      step(1, 0, 0, 0, 32'h0, 32'h0000_0040);
      step(0, 0, 1, 1, 32'h0000_0003, 32'h0);
      #2;
      clr = 1'b1;
      #1;
      check_reset_state();
      q.delete();
      m_pc = 32'h0; m_busy = 0; m_tc = 0; m_ntc = 0;
      #2;
      clr = 1'b0;
      idle(3);

      // Counter saturation on the narrow instance
      for (int i = 0; i < 5; i++) branch(32'h0000_0001, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 8) == 0, ($urandom % 2) == 1, ($urandom % 4) == 0,
              ($urandom % 2) == 1, $urandom, ($urandom % 16 == 0) ? 32'hFFFF_FFFF : $urandom);
      end
      idle(4);
      check("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
